// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus side of the load/store unit: request/write/lane signals out,
// ready and read data back.
interface lsu_bus_ctrl_if #(
    parameter int XLEN = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [XLEN-1:0]       bus_addr;
    logic [XLEN/8-1:0]     bus_be;
    logic [XLEN-1:0]       bus_wdata;
    logic                  bus_ready;
    logic [XLEN-1:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store unit: aligns and lane-shifts accesses, waits on the
// bus handshake with a timeout, and sign/zero-extends load results.
module lsu_bus_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   rdata_ext_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    lsu_bus_ctrl_if.master    bus
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mis_q, mis_d, err_q, err_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [OW-1:0]     off_q, off_d;
    logic [XLEN-1:0]   baddr_q, baddr_d, wd_q, wd_d, rdata_q, rdata_d;
    logic [BW-1:0]     be_q, be_d;

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return XLEN'(8'hFF);
            2'd1:    return XLEN'(16'hFFFF);
            2'd2:    return XLEN'(32'hFFFF_FFFF);
            default: return '1;
        endcase
    endfunction

    function automatic logic [BW-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return BW'(8'h01);
            2'd1:    return BW'(8'h03);
            2'd2:    return BW'(8'h0F);
            default: return BW'(8'hFF);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] v, input logic [2:0] f3);
        logic [XLEN-1:0] m;
        logic            s;
        m = size_mask(f3[1:0]);
        case (f3[1:0])
            2'd0:    s = v[7];
            2'd1:    s = v[15];
            2'd2:    s = v[31];
            default: s = 1'b0;
        endcase
        return (v & m) | ((s & ~f3[2]) ? ~m : '0);
    endfunction

    // Illegal encodings and non-natural alignment both end in the misalign pulse.
    function automatic logic access_bad(input logic st, input logic [2:0] f3, input logic [2:0] lo);
        logic ill, mis;
        ill = (f3 == 3'b111) || (f3[2] && st) ||
              ((XLEN == 32) && (f3 == 3'b011 || f3 == 3'b110));
        case (f3[1:0])
            2'd1:    mis = lo[0];
            2'd2:    mis = |lo[1:0];
            2'd3:    mis = |lo;
            default: mis = 1'b0;
        endcase
        return ill | mis;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        err_d   = err_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        baddr_d = baddr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (access_bad(is_store_i, funct3_i, 3'(addr_i[OW-1:0]))) begin
                        mis_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        we_d    = is_store_i;
                        f3_d    = funct3_i;
                        off_d   = addr_i[OW-1:0];
                        baddr_d = {addr_i[XLEN-1:OW], {OW{1'b0}}};
                        be_d    = lane_mask(funct3_i[1:0]) << addr_i[OW-1:0];
                        wd_d    = is_store_i ? ((wdata_i & size_mask(funct3_i[1:0]))
                                                << {addr_i[OW-1:0], 3'b000}) : '0;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A ready on the final allowed cycle still wins over the timeout.
                if (bus.bus_ready) begin
                    rdata_d = we_q ? '0 : load_ext(bus.bus_rdata >> {off_q, 3'b000}, f3_q);
                    state_d = DONE;
                end else if (cnt_d == TO) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                mis_d   = 1'b0;
                err_d   = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        f3_q    <= f3_d;
        off_q   <= off_d;
        baddr_q <= baddr_d;
        wd_q    <= wd_d;
        be_q    <= be_d;
        rdata_q <= rdata_d;
    end

    // Everything observable is gated by state, so reset alone zeroes the outputs.
    assign bus.bus_req   = (state_q == REQ);
    assign bus.bus_we    = bus.bus_req & we_q;
    assign bus.bus_addr  = bus.bus_req ? baddr_q : '0;
    assign bus.bus_be    = bus.bus_req ? be_q : '0;
    assign bus.bus_wdata = bus.bus_req ? wd_q : '0;

    assign done_o      = (state_q == DONE);
    assign misalign_o  = done_o & mis_q;
    assign bus_err_o   = done_o & err_q;
    assign rdata_ext_o = done_o ? rdata_q : '0;
    assign stall_o     = ((state_q == IDLE) & start_i) | (state_q == REQ);
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: XLEN=32 and XLEN=64 instances, directed table plus
// random transactions checked against an arithmetic reference model.
module tb_lsu_bus_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, start64 = 1'b0, is_store = 1'b0, ready = 1'b0, m64 = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [63:0] addr = '0, wdata = '0, rdata = '0;

    logic        stall32, done32, mis32, err32, stall64, done64, mis64, err64;
    logic [31:0] ext32;
    logic [63:0] ext64;

    lsu_bus_ctrl_if #(.XLEN(32)) bus32();
    lsu_bus_ctrl_if #(.XLEN(64)) bus64();
    assign bus32.bus_ready = ready;
    assign bus32.bus_rdata = rdata[31:0];
    assign bus64.bus_ready = ready;
    assign bus64.bus_rdata = rdata;

    lsu_bus_ctrl #(.XLEN(32), .TIMEOUT(TO)) u32 (
        .clk(clk), .reset(reset), .start_i(start32), .is_store_i(is_store), .funct3_i(f3),
        .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .stall_o(stall32), .done_o(done32),
        .rdata_ext_o(ext32), .misalign_o(mis32), .bus_err_o(err32), .bus(bus32)
    );
    lsu_bus_ctrl #(.XLEN(64), .TIMEOUT(TO)) u64 (
        .clk(clk), .reset(reset), .start_i(start64), .is_store_i(is_store), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .stall_o(stall64), .done_o(done64),
        .rdata_ext_o(ext64), .misalign_o(mis64), .bus_err_o(err64), .bus(bus64)
    );

    logic        o_stall, o_done, o_mis, o_err, o_req, o_we;
    logic [63:0] o_ext, o_addr, o_wdata;
    logic [7:0]  o_be;
    assign o_stall = m64 ? stall64 : stall32;
    assign o_done  = m64 ? done64 : done32;
    assign o_mis   = m64 ? mis64 : mis32;
    assign o_err   = m64 ? err64 : err32;
    assign o_ext   = m64 ? ext64 : {32'd0, ext32};
    assign o_req   = m64 ? bus64.bus_req : bus32.bus_req;
    assign o_we    = m64 ? bus64.bus_we : bus32.bus_we;
    assign o_addr  = m64 ? bus64.bus_addr : {32'd0, bus32.bus_addr};
    assign o_wdata = m64 ? bus64.bus_wdata : {32'd0, bus32.bus_wdata};
    assign o_be    = m64 ? bus64.bus_be : {4'd0, bus32.bus_be};

    typedef struct {
        logic        m64;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr, wdata, rdata;
        int          waits;     // wait states before ready; -1 = never ready
    } vec_t;
    typedef struct {
        logic        mis, err;
        logic [63:0] baddr;
        logic [7:0]  be;
        logic [63:0] bwd, ext;
        int          done_cyc, reqc;
    } exp_t;
    typedef struct { vec_t v; exp_t e; } rec_t;

    int nvec = 0, nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t mk(input logic m, input logic st, input logic [2:0] fn,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                                input int w, input logic mis, input logic err,
                                input logic [63:0] ba, input logic [7:0] be,
                                input logic [63:0] bwd, input logic [63:0] ext,
                                input int dc, input int rc);
        rec_t r;
        r.v.m64 = m; r.v.st = st; r.v.f3 = fn; r.v.addr = a; r.v.wdata = wd; r.v.rdata = rd;
        r.v.waits = w;
        r.e.mis = mis; r.e.err = err; r.e.baddr = ba; r.e.be = be; r.e.bwd = bwd; r.e.ext = ext;
        r.e.done_cyc = dc; r.e.reqc = rc;
        return r;
    endfunction

    // Reference: derived from sizes, offsets and modular arithmetic on the access.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          n, xb, off;
        logic [63:0] xm, fm, fld;
        logic        illegal;
        n  = 1 << v.f3[1:0];
        xb = v.m64 ? 8 : 4;
        xm = v.m64 ? '1 : 64'hFFFF_FFFF;
        illegal = (v.f3 == 3'b111) || (v.st && v.f3[2]) ||
                  (!v.m64 && (v.f3 == 3'b011 || v.f3 == 3'b110));
        e.mis   = illegal || ((v.addr % n) != 0);
        off     = int'(v.addr % xb);
        fm      = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        e.baddr = v.addr - 64'(off);
        e.be    = 8'(((1 << n) - 1) << off);
        e.bwd   = v.st ? (((v.wdata & fm) << (8 * off)) & xm) : 64'd0;
        fld     = (v.rdata >> (8 * off)) & fm;
        if (!v.f3[2] && fld[8 * n - 1]) fld = fld | ~fm;
        e.ext   = fld & xm;
        e.err   = !e.mis && (v.waits < 0 || v.waits >= TO);
        if (e.mis || e.err) e.ext = '0;
        e.done_cyc = e.mis ? 1 : (e.err ? TO + 1 : v.waits + 2);
        e.reqc     = e.mis ? 0 : (e.err ? TO : v.waits + 1);
        return e;
    endfunction

    task automatic run(input vec_t v, input exp_t e, input string tag);
        int   cyc, reqc;
        logic seen, stall_bad, first;
        step();
        m64 = v.m64; is_store = v.st; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        ready = 1'b0; rdata = {$urandom, $urandom};
        start32 = !v.m64; start64 = v.m64;
        cyc = 0; reqc = 0; seen = 1'b0; stall_bad = 1'b0; first = 1'b1;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                chk({tag, " misalign"}, 64'(o_mis), 64'(e.mis));
                chk({tag, " bus_err"}, 64'(o_err), 64'(e.err));
                chk({tag, " stall_at_done"}, 64'(o_stall), 64'd0);
                if (!v.st || e.mis || e.err) chk({tag, " rdata_ext"}, o_ext, e.ext);
                chk({tag, " done_cycle"}, 64'(cyc), 64'(e.done_cyc));
                chk({tag, " req_cycles"}, 64'(reqc), 64'(e.reqc));
                chk({tag, " stall_while_busy"}, 64'(stall_bad), 64'd0);
            end else begin
                if (!o_stall) stall_bad = 1'b1;
                if (o_req) begin
                    reqc++;
                    if (first) begin
                        first = 1'b0;
                        chk({tag, " bus_we"}, 64'(o_we), 64'(v.st));
                        chk({tag, " bus_addr"}, o_addr, e.baddr);
                        chk({tag, " bus_be"}, 64'(o_be), 64'(e.be));
                        chk({tag, " bus_wdata"}, o_wdata, e.bwd);
                    end
                end
                step();
                cyc++;
                ready = (reqc == v.waits);
                rdata = ready ? v.rdata : {$urandom, $urandom};
            end
        end
        if (!seen) chk({tag, " done_within_budget"}, 64'd0, 64'd1);
        step();
        start32 = 1'b0; start64 = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(o_done), 64'd0);
        chk({tag, " stall_after"}, 64'(o_stall), 64'd0);
    endtask

    rec_t tbl[14];

    initial begin
        tbl[0]  = mk(1'b0, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80AABBCC, 0,
                     1'b0, 1'b0, 64'h1000, 8'h08, 64'h0, 64'hFFFFFF80, 2, 1);
        tbl[1]  = mk(1'b0, 1'b1, 3'b001, 64'h2002, 64'h1234ABCD, 64'h0, 0,
                     1'b0, 1'b0, 64'h2000, 8'h0C, 64'hABCD0000, 64'h0, 2, 1);
        tbl[2]  = mk(1'b0, 1'b0, 3'b010, 64'h3001, 64'h0, 64'h0, 0,
                     1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
        tbl[3]  = mk(1'b0, 1'b0, 3'b101, 64'h0010, 64'h0, 64'h0, -1,
                     1'b0, 1'b1, 64'h0010, 8'h03, 64'h0, 64'h0, 5, 4);
        tbl[4]  = mk(1'b1, 1'b0, 3'b110, 64'h4004, 64'h0, 64'hF0000001_00000000, 0,
                     1'b0, 1'b0, 64'h4000, 8'hF0, 64'h0, 64'h00000000_F0000001, 2, 1);
        tbl[5]  = mk(1'b0, 1'b1, 3'b100, 64'h5000, 64'hFF, 64'h0, 0,
                     1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
        tbl[6]  = mk(1'b0, 1'b0, 3'b011, 64'h6000, 64'h0, 64'h0, 0,
                     1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
        tbl[7]  = mk(1'b1, 1'b1, 3'b011, 64'h0008, 64'h11223344_55667788, 64'h0, 2,
                     1'b0, 1'b0, 64'h0008, 8'hFF, 64'h11223344_55667788, 64'h0, 4, 3);
        tbl[8]  = mk(1'b0, 1'b0, 3'b001, 64'h6002, 64'h0, 64'h80010000, 3,
                     1'b0, 1'b0, 64'h6000, 8'h0C, 64'h0, 64'hFFFF8001, 5, 4);
        tbl[9]  = mk(1'b1, 1'b0, 3'b000, 64'h0007, 64'h0, 64'h7F123456_78ABCDEF, 0,
                     1'b0, 1'b0, 64'h0000, 8'h80, 64'h0, 64'h7F, 2, 1);
        tbl[10] = mk(1'b0, 1'b0, 3'b010, 64'h0020, 64'h0, 64'hDEADBEEF, 3,
                     1'b0, 1'b0, 64'h0020, 8'h0F, 64'h0, 64'hDEADBEEF, 5, 4);
        tbl[11] = mk(1'b1, 1'b0, 3'b010, 64'h0004, 64'h0, 64'h80000000_00000000, 1,
                     1'b0, 1'b0, 64'h0000, 8'hF0, 64'h0, 64'hFFFFFFFF_80000000, 3, 2);
        tbl[12] = mk(1'b0, 1'b0, 3'b111, 64'h0100, 64'h0, 64'h0, 0,
                     1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);
        tbl[13] = mk(1'b1, 1'b1, 3'b010, 64'h0106, 64'h5, 64'h0, 0,
                     1'b1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1, 0);

        // Reset state on both widths
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            m64 = (w == 1);
            #1;
            chk("reset stall", 64'(o_stall), 64'd0);
            chk("reset done", 64'(o_done), 64'd0);
            chk("reset bus_req", 64'(o_req), 64'd0);
            chk("reset rdata_ext", o_ext, 64'd0);
        end
        step();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run(tbl[i].v, tbl[i].e, $sformatf("tbl%0d", i));

        for (int i = 0; i < 150; i++) begin
            vec_t v;
            int   n, w;
            v.m64   = 1'($urandom_range(0, 1));
            v.st    = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            n       = 1 << v.f3[1:0];
            v.addr  = {$urandom, $urandom} & ~64'h7;
            v.addr  = v.addr | (($urandom_range(0, 4) == 0) ? 64'($urandom_range(0, 7))
                                                           : 64'($urandom_range(0, 7) & ~(n - 1)));
            v.wdata = {$urandom, $urandom};
            v.rdata = {$urandom, $urandom};
            if (!v.m64) begin
                v.addr  = v.addr & 64'hFFFF_FFFF;
                v.wdata = v.wdata & 64'hFFFF_FFFF;
                v.rdata = v.rdata & 64'hFFFF_FFFF;
            end
            w       = $urandom_range(0, 5);
            v.waits = (w == 5) ? -1 : w;
            run(v, model(v), $sformatf("rnd%0d", i));
        end

        // Reset while waiting in REQ after three wait states
        step();
        m64 = 1'b0; is_store = 1'b0; f3 = 3'b010; addr = 64'h40; ready = 1'b0;
        start32 = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("midreset req_before", 64'(o_req), 64'd1);
        start32 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset bus_req_async", 64'(o_req), 64'd0);
        chk("midreset stall", 64'(o_stall), 64'd0);
        chk("midreset done", 64'(o_done), 64'd0);
        step();
        reset = 1'b0;
        ready = 1'b1;
        rdata = 64'hCAFE_F00D;
        begin
            logic bad;
            bad = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (o_done || o_req) bad = 1'b1;
            end
            chk("midreset no_done_after", 64'(bad), 64'd0);
        end
        ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
